// File: rtl/cnt_fnd_scan.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_fnd_scan
//  Description : Shows a 4-bit count (0..15) as a decimal number on a 4-digit
//                common-anode multiplexed 7-segment display. The module has
//                its own refresh prescaler and digit-scan counter. It takes a
//                snapshot of the count once per scan frame so that a frame
//                never mixes two different values.
//  Revision    : 1.0  initial release
// ============================================================================
module cnt_fnd_scan #(
    parameter int DIV = 100000              // clock cycles per digit slot
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] i_cnt,
    input  logic       i_blank,
    output logic [3:0] o_fnd_com,
    output logic [7:0] o_fnd_data,
    output logic       o_frame_tick
);

    // Prescaler width; a DIV of 1 still needs one bit, which is held at 0
    localparam int             c_PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(DIV - 1);

    localparam logic [7:0] c_SEG_BLANK = 8'hFF;
    localparam logic [7:0] c_SEG_ONE   = 8'hF9;

    logic [c_PRE_W-1:0] r_pre_cnt;
    logic [1:0]         r_idx;
    logic [3:0]         r_snap;

    logic               w_tick;
    logic               w_snap_take;
    logic [1:0]         w_idx_nxt;
    logic [3:0]         w_snap_nxt;
    logic [3:0]         w_ones;
    logic               w_tens;
    logic [3:0]         w_com_nxt;
    logic [7:0]         w_data_nxt;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one decimal digit
    function automatic logic [7:0] seg_of(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    // Slot timing and the frame-boundary snapshot condition
    always_comb begin
        w_tick      = (r_pre_cnt == c_PRE_MAX);
        w_snap_take = w_tick && (r_idx == 2'd3);
        w_idx_nxt   = w_tick ? (r_idx + 2'd1) : r_idx;
        w_snap_nxt  = w_snap_take ? i_cnt : r_snap;
    end

    // Digit decode for the slot that will be shown after this edge
    always_comb begin
        w_tens     = (w_snap_nxt >= 4'd10);
        w_ones     = w_tens ? (w_snap_nxt - 4'd10) : w_snap_nxt;
        w_com_nxt  = ~(4'b0001 << w_idx_nxt);
        w_data_nxt = c_SEG_BLANK;
        case (w_idx_nxt)
            2'd0:    w_data_nxt = seg_of(w_ones);
            2'd1:    w_data_nxt = w_tens ? c_SEG_ONE : c_SEG_BLANK;
            default: w_data_nxt = c_SEG_BLANK;
        endcase
    end

    // Prescaler, scan index and per-frame snapshot; these keep running while blanked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre_cnt <= '0;
            r_idx     <= 2'd0;
            r_snap    <= 4'd0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : (r_pre_cnt + c_PRE_W'(1));
            r_idx     <= w_idx_nxt;
            r_snap    <= w_snap_nxt;
        end
    end

    // Registered display outputs. Reloading the decode on every unblanked edge
    // gives the same value as holding between ticks, and it also restores the
    // current slot on the first edge after blanking ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_fnd_com    <= 4'b1110;
            o_fnd_data   <= 8'hC0;
            o_frame_tick <= 1'b0;
        end else begin
            o_frame_tick <= w_snap_take;
            if (i_blank) begin
                o_fnd_com  <= 4'b1111;
                o_fnd_data <= c_SEG_BLANK;
            end else begin
                o_fnd_com  <= w_com_nxt;
                o_fnd_data <= w_data_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnt_fnd_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnt_fnd_scan
//  Description : Self-checking bench for cnt_fnd_scan (DIV=4). A behavioural
//                model predicts the outputs on every edge into a scoreboard
//                queue, and directed checks pin down the key display values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cnt_fnd_scan;

    localparam int DIV = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] i_cnt   = 4'd0;
    logic       i_blank = 1'b0;
    logic [3:0] o_fnd_com;
    logic [7:0] o_fnd_data;
    logic       o_frame_tick;

    always #5 clk = ~clk;

    cnt_fnd_scan #(.DIV(DIV)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_cnt        (i_cnt),
        .i_blank      (i_blank),
        .o_fnd_com    (o_fnd_com),
        .o_fnd_data   (o_fnd_data),
        .o_frame_tick (o_frame_tick)
    );

    typedef struct packed {
        logic [3:0] com;
        logic [7:0] data;
        logic       ft;
    } exp_t;

    exp_t sb_q[$];

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int last_ft = -1;

    // Reference model state
    int         m_pre;
    int         m_idx;
    logic [3:0] m_snap;
    exp_t       m_out;

    logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] slot_data(input int slot, input logic [3:0] v);
        int n;
        n = int'(v);
        if (slot == 0) return seg_tab[n % 10];
        if (slot == 1 && n >= 10) return seg_tab[n / 10];
        return 8'hFF;
    endfunction

    task automatic model_reset();
        m_pre  = 0;
        m_idx  = 0;
        m_snap = 4'd0;
        m_out  = '{com: 4'b1110, data: 8'hC0, ft: 1'b0};
    endtask

    // One rising edge of the reference model, using the currently driven inputs
    task automatic model_edge();
        bit tick;
        tick     = (m_pre == DIV - 1);
        m_out.ft = tick && (m_idx == 3);
        if (m_out.ft) m_snap = i_cnt;
        if (tick) m_idx = (m_idx + 1) % 4;
        m_pre = tick ? 0 : m_pre + 1;
        if (i_blank) begin
            m_out.com  = 4'b1111;
            m_out.data = 8'hFF;
        end else begin
            m_out.com  = 4'(~(4'b0001 << m_idx));
            m_out.data = slot_data(m_idx, m_snap);
        end
    endtask

    // Advance one clock: predict at the rising edge, compare at the falling edge
    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        sb_q.push_back(m_out);
        @(negedge clk);
        cyc++;
        e = sb_q.pop_front();
        chk("sb.com",  o_fnd_com,    e.com);
        chk("sb.data", o_fnd_data,   e.data);
        chk("sb.ft",   o_frame_tick, e.ft);
        if (o_frame_tick) begin
            if (last_ft >= 0) chk("ft.period", cyc - last_ft, 16);
            last_ft = cyc;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 40; i++) begin
            step();
            if (o_frame_tick) return;
        end
        chk("frame.timeout", 0, 1);
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] com, input logic [7:0] data);
        chk({tag, ".com"},  o_fnd_com,  com);
        chk({tag, ".data"}, o_fnd_data, data);
    endtask

    initial begin
        bit found;
        model_reset();

        // 1. Reset held for three cycles, then released
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_disp("rst", 4'b1110, 8'hC0);
            chk("rst.ft", o_frame_tick, 0);
        end
        reset_n = 1'b1;
        steps(3);
        chk_disp("pre_tick", 4'b1110, 8'hC0);
        step();
        chk_disp("first_tick", 4'b1101, 8'hFF);

        // 2. Value 3 over two full frames
        i_cnt = 4'd3;
        wait_frame();
        chk_disp("v3.slot0", 4'b1110, 8'hB0);
        steps(4);
        chk_disp("v3.slot1", 4'b1101, 8'hFF);
        steps(4);
        chk_disp("v3.slot2", 4'b1011, 8'hFF);
        steps(4);
        chk_disp("v3.slot3", 4'b0111, 8'hFF);
        wait_frame();
        chk_disp("v3.slot0b", 4'b1110, 8'hB0);

        // 3. Value 12
        i_cnt = 4'd12;
        wait_frame();
        chk_disp("v12.slot0", 4'b1110, 8'hA4);
        steps(4);
        chk_disp("v12.slot1", 4'b1101, 8'hF9);

        // 4. Change the count mid-frame; the current frame must not tear
        i_cnt = 4'd1;
        step();
        chk_disp("tear.slot1", 4'b1101, 8'hF9);
        wait_frame();
        chk_disp("tear.next0", 4'b1110, 8'hF9);
        steps(4);
        chk_disp("tear.next1", 4'b1101, 8'hFF);

        // 5. Blank for ten cycles; scan phase continues underneath
        i_blank = 1'b1;
        step();
        chk_disp("blank", 4'b1111, 8'hFF);
        steps(9);
        i_blank = 1'b0;
        step();
        chk("unblank.lit", (o_fnd_com == 4'b1111) ? 1 : 0, 0);
        wait_frame();
        wait_frame();

        // 6. Asynchronous reset pulse while slot 2 is displayed
        i_cnt = 4'd7;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_idx == 2) found = 1'b1;
            else step();
        end
        if (!found) chk("idx2.timeout", 0, 1);
        reset_n = 1'b0;
        #1;
        chk_disp("mid_rst", 4'b1110, 8'hC0);
        chk("mid_rst.ft", o_frame_tick, 0);
        model_reset();
        last_ft = -1;
        @(posedge clk);
        @(negedge clk);
        chk_disp("mid_rst.hold", 4'b1110, 8'hC0);
        reset_n = 1'b1;
        steps(4);
        chk_disp("restart.slot1", 4'b1101, 8'hFF);
        wait_frame();
        chk_disp("restart.slot0", 4'b1110, 8'hF8);
        wait_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cnt_fnd_scan.md
Name: cnt_fnd_scan

Overview:
- Downstream consumer of the 4-bit count produced by counter_100.
- Shows that count as a decimal number (0..15) on a 4-digit, common-anode, multiplexed 7-segment (FND) display.
- Contains its own refresh prescaler and digit-scan counter.
- Snapshots the input once per scan frame so a digit cannot change partway through a frame.

Parameters:
- DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz). Legal range 1..2^20. Simulation uses 4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_cnt  input  4  count value to display (connects to counter_100 o_cnt).
- i_blank  input  1  1 = turn all digits off; scanning continues.
- o_fnd_com  output  4  digit commons, active-low, one-hot-low. Bit 0 = ones digit, bit 3 = leftmost digit.
- o_fnd_data  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- o_frame_tick  output  1  one-cycle pulse on the clock edge where a new snapshot is taken.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - internal state: pre_cnt=0, idx=0, snap=0.
  - outputs: o_fnd_com=4'b1110, o_fnd_data=8'hC0 (digit "0"), o_frame_tick=0.
  - All outputs hold these values for as long as reset_n=0, including when reset is asserted mid-frame.
- Prescaler:
  - pre_cnt counts 0..DIV-1, then wraps to 0.
  - tick = (pre_cnt==DIV-1).
  - With DIV=1, tick is high every cycle.
  - The first tick after reset release occurs DIV cycles after release.
- Scan counter:
  - idx (2 bits) increments on tick and wraps 3->0.
  - No change when tick=0.
- Snapshot: on the edge where tick=1 and idx==3:
  - snap <= i_cnt;
  - o_frame_tick <= 1.
  - On every other edge, o_frame_tick <= 0.
  - i_cnt changes at any other time are ignored until the next snapshot.
- Digit decode, using snapD = the new snap on a snapshot edge, otherwise the held snap:
  - slot 0: seg(snapD mod 10).
  - slot 1: seg(1) if snapD>=10, else blank (leading-zero suppression).
  - slots 2 and 3: always blank.
- Segment codes (hex): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF. The dp bit is always 1 (off).
- Output registers:
  - o_fnd_com and o_fnd_data are registered.
  - On a tick edge they take the values for the new idx; on non-tick edges they hold.
  - o_fnd_com = ~(4'b0001 << idx_new).
  - A blank digit still drives its own common low, with data=FF.
- Blanking:
  - i_blank is sampled on every edge.
  - If i_blank=1, the registered outputs become o_fnd_com=4'b1111 and o_fnd_data=8'hFF on the next edge, regardless of tick.
  - idx, pre_cnt and snap keep advancing while blanked.
  - If i_blank falls: the next edge restores the current slot's com/data, computed from the held idx and snap.
- Simultaneous events:
  - tick with idx==3 and i_blank=1: the snapshot is still taken and o_frame_tick still pulses; outputs stay blank.
- No combinational path from any input to any output.

Test Plan (DIV=4):
1. Reset check: reset_n=0 for 3 cycles, then release. Outputs are 1110/C0 during reset. The first tick comes 4 cycles after release: com=1101, data=FF (tens blank for 0).
2. Value 3: i_cnt=3 held, run 2 full frames (32 cycles). o_frame_tick pulses every 16 cycles. Slot 0 shows B0. Slots 1, 2, 3 show FF with commons 1101, 1011, 0111 in order.
3. Value 12: i_cnt=12. After the next o_frame_tick, slot 0 = A4 and slot 1 = F9.
4. Tearing: change i_cnt 12->1 while idx==1. Slots 1..3 of the current frame are unchanged (slot 1 still F9). The next frame shows F9 on slot 0 and FF on slot 1.
5. Blank: assert i_blank for 10 cycles. Outputs are 1111/FF one edge later. After deassertion the scan phase continues with no slip (o_frame_tick period still 16).
6. Mid-frame reset: pulse reset_n low for 1 cycle at idx==2. Outputs go to 1110/C0 asynchronously, snap reads 0, and the scan restarts from slot 0.
